// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the 64-bit ALU.
// Registers decoded operands, resolves main-control ALUOp plus funct bits into
// the 4-bit ALU function code, selects reg/imm for operand b, and applies
// EX/MEM forwarding both at capture and while the stage is stalled.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid / in_ready            decode-side handshake (in_ready is combinational)
//   rs1_idx, rs2_idx, rs1_data, rs2_data, imm, alu_src,
//   alu_op_main, funct3, funct7_b30, rd_in, reg_write_in   decoded instruction
//   fwd_en, fwd_rd, fwd_data       EX/MEM forwarding source
//   flush                          kills held and incoming instruction
//   out_valid / out_ready          execute-side handshake
//   a, b, store_data, alu_op, rd, reg_write, is_branch, illegal   registered ALU inputs
module alu_issue_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] rs1_idx,
  input  logic [REGW-1:0] rs2_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      alu_op_main,
  input  logic [2:0]      funct3,
  input  logic            funct7_b30,
  input  logic [REGW-1:0] rd_in,
  input  logic            reg_write_in,
  input  logic            fwd_en,
  input  logic [REGW-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] store_data,
  output logic [3:0]      alu_op,
  output logic [REGW-1:0] rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic            illegal
);

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_AND = 4'b0000;
  localparam logic [OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;
  localparam logic [OPW-1:0] OP_NOR = 4'b1100;
  localparam logic [OPW-1:0] OP_BAD = 4'b1111;

  // Held state
  logic            valid_q,     valid_d;
  logic [XLEN-1:0] a_q,         a_d;
  logic [XLEN-1:0] b_q,         b_d;
  logic [XLEN-1:0] sd_q,        sd_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [OPW-1:0]  alu_op_q,    alu_op_d;
  logic [REGW-1:0] rd_q,        rd_d;
  logic [REGW-1:0] rs1_idx_q,   rs1_idx_d;
  logic [REGW-1:0] rs2_idx_q,   rs2_idx_d;
  logic            alu_src_q,   alu_src_d;
  logic            reg_write_q, reg_write_d;
  logic            is_branch_q, is_branch_d;
  logic            illegal_q,   illegal_d;

  // Decode and handshake helpers
  logic [OPW-1:0]  op_dec;
  logic            illegal_dec;
  logic            capture;
  logic            hold;
  logic            cap_m1, cap_m2, hold_m1, hold_m2;
  logic [XLEN-1:0] cap_r2;

  // Forwarding never applies to x0
  function automatic logic fwd_match(input logic en, input logic [REGW-1:0] frd,
                                     input logic [REGW-1:0] idx);
    return en && (frd != '0) && (frd == idx);
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = valid_q && !out_ready && !flush;

  // ALUOp resolution from main control plus funct bits
  always_comb begin
    op_dec      = OP_BAD;
    illegal_dec = 1'b1;
    case (alu_op_main)
      2'b00: begin op_dec = OP_ADD; illegal_dec = 1'b0; end
      2'b01: begin op_dec = OP_SUB; illegal_dec = 1'b0; end
      2'b10: begin
        case ({funct7_b30, funct3})
          4'b0_000: begin op_dec = OP_ADD; illegal_dec = 1'b0; end
          4'b1_000: begin op_dec = OP_SUB; illegal_dec = 1'b0; end
          4'b0_111: begin op_dec = OP_AND; illegal_dec = 1'b0; end
          4'b0_110: begin op_dec = OP_OR;  illegal_dec = 1'b0; end
          4'b1_100: begin op_dec = OP_NOR; illegal_dec = 1'b0; end
          default:  begin op_dec = OP_BAD; illegal_dec = 1'b1; end
        endcase
      end
      default: begin op_dec = OP_BAD; illegal_dec = 1'b1; end
    endcase
  end

  assign cap_m1  = fwd_match(fwd_en, fwd_rd, rs1_idx);
  assign cap_m2  = fwd_match(fwd_en, fwd_rd, rs2_idx);
  assign hold_m1 = fwd_match(fwd_en, fwd_rd, rs1_idx_q);
  assign hold_m2 = fwd_match(fwd_en, fwd_rd, rs2_idx_q);
  assign cap_r2  = cap_m2 ? fwd_data : rs2_data;

  // Next-state: flush beats capture beats hold; otherwise the stage drains
  always_comb begin
    valid_d     = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    sd_d        = sd_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    alu_src_d   = alu_src_q;
    reg_write_d = 1'b0;
    is_branch_d = 1'b0;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      a_d         = cap_m1 ? fwd_data : rs1_data;
      b_d         = alu_src ? imm : cap_r2;
      sd_d        = cap_r2;
      imm_d       = imm;
      alu_op_d    = op_dec;
      rd_d        = rd_in;
      rs1_idx_d   = rs1_idx;
      rs2_idx_d   = rs2_idx;
      alu_src_d   = alu_src;
      illegal_d   = illegal_dec;
      reg_write_d = reg_write_in && !illegal_dec;
      is_branch_d = (alu_op_main == 2'b01);
    end else if (hold) begin
      // Late-arriving EX/MEM results still reach a stalled instruction
      valid_d     = 1'b1;
      reg_write_d = reg_write_q;
      is_branch_d = is_branch_q;
      if (hold_m1) a_d = fwd_data;
      if (hold_m2) sd_d = fwd_data;
      b_d = alu_src_q ? imm_q : (hold_m2 ? fwd_data : b_q);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sd_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      is_branch_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sd_q        <= sd_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      is_branch_q <= is_branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = valid_q;
  assign a          = a_q;
  assign b          = b_q;
  assign store_data = sd_q;
  assign alu_op     = alu_op_q;
  assign rd         = rd_q;
  assign reg_write  = reg_write_q;
  assign is_branch  = is_branch_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Registers decoded operands and resolves the 2-bit main-control ALUOp plus funct bits into the ALU's 4-bit ALUOp code.
- Selects register or immediate for operand b and applies EX/MEM forwarding, both at capture and while stalled.
- Decouples decode from execute with a valid/ready handshake, and supports flush for branch mispredicts.

Parameters:
- XLEN, 64, datapath width; must match the ALU.
- REGW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_idx  in  REGW  source register 1 index
- rs2_idx  in  REGW  source register 2 index
- rs1_data  in  XLEN  register file read data 1
- rs2_data  in  XLEN  register file read data 2
- imm  in  XLEN  sign-extended immediate
- alu_src  in  1  1 = operand b is imm, 0 = operand b is rs2
- alu_op_main  in  2  main-control ALUOp
- funct3  in  3  instruction funct3
- funct7_b30  in  1  instruction bit 30
- rd_in  in  REGW  destination index
- reg_write_in  in  1  writeback enable
- fwd_en  in  1  EX/MEM result valid for forwarding
- fwd_rd  in  REGW  EX/MEM destination index
- fwd_data  in  XLEN  EX/MEM result
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute stage consumes this cycle
- a  out  XLEN  ALU operand a
- b  out  XLEN  ALU operand b
- store_data  out  XLEN  forwarded rs2 value
- alu_op  out  4  ALU function code
- rd  out  REGW  destination index
- reg_write  out  1  writeback enable, gated by valid
- is_branch  out  1  alu_op_main == 01
- illegal  out  1  unrecognised function

Behaviour:
- Reset (async, rst_n = 0): all outputs and held registers go to 0. This includes out_valid = 0, alu_op = 0000, and the held alu_src, imm, rs1_idx and rs2_idx.
- Single register stage; latency 1 cycle.
- in_ready = !out_valid || out_ready. Purely combinational; does not depend on in_valid.
- Capture happens when in_valid && in_ready && !flush. Next cycle out_valid = 1.
- If in_ready && !(in_valid && !flush), the next cycle has out_valid = 0.
- When out_valid && !out_ready, all outputs hold stable, except for forwarding updates (below).
- flush: the next cycle has out_valid = 0, regardless of in_valid, in_ready or out_ready. Flush has priority over capture and over hold.
- Forward match for index x: fwd_en && fwd_rd != 0 && fwd_rd == x.
- Capture path:
  - a = rs1 match ? fwd_data : rs1_data.
  - r2 = rs2 match ? fwd_data : rs2_data.
  - b = alu_src ? imm : r2.
  - store_data = r2.
- Hold path (out_valid && !out_ready && !flush), evaluated against the held rs1_idx and rs2_idx:
  - On an rs1 match, a updates to fwd_data.
  - On an rs2 match, store_data updates to fwd_data; b also updates only if the held alu_src = 0.
- Index 0 never forwards; register x0 reads come from rs1_data/rs2_data unchanged.
- ALUOp resolution, registered at capture:
  - alu_op_main 00 -> 0010 (ADD, load/store address).
  - alu_op_main 01 -> 0110 (SUB, branch compare).
  - alu_op_main 10, keyed on {funct7_b30, funct3}:
    - 0_000 -> 0010
    - 1_000 -> 0110
    - 0_111 -> 0000
    - 0_110 -> 0001
    - 1_100 -> 1100 (NOR)
    - any other value -> 1111 with illegal = 1.
  - alu_op_main 11 -> 1111 with illegal = 1.
- Whenever illegal = 1, reg_write = 0.
- reg_write and is_branch are forced to 0 whenever out_valid = 0.
- Simultaneous consume and capture (out_valid && out_ready && in_valid): the new instruction replaces the old one with no bubble, giving full throughput.
- No arithmetic is performed in this stage; all widths pass through unchanged at XLEN.

Test Plan:
1. Reset, then R-type ADD: rs1_data = 5, rs2_data = 7, alu_op_main = 10, funct = 0_000, alu_src = 0 -> next cycle out_valid = 1, a = 5, b = 7, alu_op = 0010, reg_write = 1.
2. Load: imm = 0xFFFF_FFFF_FFFF_FFF8, alu_src = 1, alu_op_main = 00 -> b = 0xFFFF_FFFF_FFFF_FFF8, alu_op = 0010, store_data = rs2_data. Then beq with alu_op_main = 01 -> alu_op = 0110, is_branch = 1.
3. Forwarding:
   - rs1_idx = 3, fwd_en = 1, fwd_rd = 3, fwd_data = 0xDEAD -> a = 0xDEAD.
   - Repeat with rs1_idx = 0 and fwd_rd = 0 -> a = rs1_data.
4. Stall with update: out_ready = 0 for 3 cycles -> outputs hold and in_ready = 0. In cycle 2, fwd_rd matches the held rs2 with held alu_src = 0 -> b = store_data = fwd_data; a unchanged.
5. Flush during stall plus incoming valid -> next cycle out_valid = 0, reg_write = 0. Async rst_n pulse mid-hold -> outputs clear to 0 immediately.
6. Back-to-back: in_valid = 1 and out_ready = 1 for 4 cycles -> 4 consecutive distinct outputs with no bubbles. Also {funct7_b30, funct3} = 0_001 with alu_op_main = 10 -> alu_op = 1111, illegal = 1, reg_write = 0.
